// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin credit accumulation, per-product pricing,
// and greedy largest-coin-first change/refund return.
module vending_machine_multi #(
    parameter int                            NUM_PROD   = 4,
    parameter int                            PRICE_W    = 8,
    parameter logic [NUM_PROD*PRICE_W-1:0]   PRICES     = {8'd65, 8'd50, 8'd35, 8'd20},
    parameter int                            COIN1      = 5,
    parameter int                            COIN2      = 10,
    parameter int                            COIN3      = 25,
    parameter int                            MAX_CREDIT = 100,
    parameter int                            CREDIT_W   = 8,
    localparam int                           ID_W       = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [ID_W-1:0]     sel_id,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                product_valid,
    output logic [ID_W-1:0]     product_id,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                coin_reject,
    output logic                sel_deny
);

    // state    | meaning
    // S_IDLE   | no credit, waiting for coins
    // S_CREDIT | credit > 0, accepting coins, selections, cancel
    // S_VEND   | one-cycle dispense pulse
    // S_CHANGE | returning credit one coin per cycle
    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

    localparam logic [CREDIT_W:0] C1   = (CREDIT_W+1)'(COIN1);
    localparam logic [CREDIT_W:0] C2   = (CREDIT_W+1)'(COIN2);
    localparam logic [CREDIT_W:0] C3   = (CREDIT_W+1)'(COIN3);
    localparam logic [CREDIT_W:0] MAXC = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              state, state_nx;
    logic [CREDIT_W-1:0] credit_r, credit_nx;
    logic [ID_W-1:0]     pid_r, pid_nx;
    logic                rej_r, rej_nx;
    logic                deny_r, deny_nx;

    logic [CREDIT_W:0]   credit_ext, coin_val, coin_sum, sel_price, chg_val;
    logic [1:0]          chg_code;
    logic                cancel_ok, sel_ok, sel_in_range;

    assign credit_ext = {1'b0, credit_r};
    assign coin_sum   = credit_ext + coin_val;

    always_comb begin
        coin_val = '0;
        case (coin)
            2'b01:   coin_val = C1;
            2'b10:   coin_val = C2;
            2'b11:   coin_val = C3;
            default: coin_val = '0;
        endcase
    end

    always_comb begin
        sel_price = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (sel_id == ID_W'(i)) begin
                sel_price = (CREDIT_W+1)'(PRICES[i*PRICE_W +: PRICE_W]);
            end
        end
    end

    assign sel_in_range = (int'(sel_id) < NUM_PROD);
    assign cancel_ok    = cancel && (credit_r != '0);
    assign sel_ok       = sel_valid && sel_in_range && (credit_ext >= sel_price);

    // Greedy change: largest denomination not exceeding the remaining credit
    always_comb begin
        chg_code = 2'b00;
        chg_val  = '0;
        if (credit_ext >= C3) begin
            chg_code = 2'b11;
            chg_val  = C3;
        end else if (credit_ext >= C2) begin
            chg_code = 2'b10;
            chg_val  = C2;
        end else if (credit_ext >= C1) begin
            chg_code = 2'b01;
            chg_val  = C1;
        end
    end

    always_comb begin
        state_nx  = state;
        credit_nx = credit_r;
        pid_nx    = pid_r;
        rej_nx    = 1'b0;
        deny_nx   = 1'b0;
        case (state)
            S_IDLE, S_CREDIT: begin
                if (cancel_ok) begin
                    state_nx = S_CHANGE;
                    rej_nx   = (coin != 2'b00);
                end else if (sel_ok) begin
                    credit_nx = CREDIT_W'(credit_ext - sel_price);
                    pid_nx    = sel_id;
                    state_nx  = S_VEND;
                    rej_nx    = (coin != 2'b00);
                end else begin
                    deny_nx = sel_valid;
                    if (coin != 2'b00) begin
                        if (coin_sum <= MAXC) begin
                            credit_nx = CREDIT_W'(coin_sum);
                            state_nx  = S_CREDIT;
                        end else begin
                            rej_nx = 1'b1;
                        end
                    end
                end
            end
            S_VEND: begin
                rej_nx   = (coin != 2'b00);
                state_nx = (credit_r != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                rej_nx = (coin != 2'b00);
                // A residue below the smallest coin cannot be paid out; drop it rather than stall
                if ((credit_ext <= chg_val) || (chg_val == '0)) begin
                    credit_nx = '0;
                    state_nx  = S_IDLE;
                end else begin
                    credit_nx = CREDIT_W'(credit_ext - chg_val);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            credit_r <= '0;
            pid_r    <= '0;
            rej_r    <= 1'b0;
            deny_r   <= 1'b0;
        end else begin
            state    <= state_nx;
            credit_r <= credit_nx;
            pid_r    <= pid_nx;
            rej_r    <= rej_nx;
            deny_r   <= deny_nx;
        end
    end

    assign credit        = credit_r;
    assign busy          = (state == S_VEND) || (state == S_CHANGE);
    assign product_valid = (state == S_VEND);
    assign product_id    = product_valid ? pid_r : '0;
    assign change_valid  = (state == S_CHANGE);
    assign change_coin   = change_valid ? chg_code : 2'b00;
    assign coin_reject   = rej_r;
    assign sel_deny      = deny_r;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios then random traffic, all checked
// against a schedule-of-outputs reference model.
module tb_vending_machine_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] coin = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'b00;
    logic       cancel = 1'b0;
    logic [7:0] credit;
    logic       busy, product_valid, change_valid, coin_reject, sel_deny;
    logic [1:0] product_id, change_coin;

    vending_machine_multi dut (
        .clk(clk), .rst(rst), .coin(coin), .sel_valid(sel_valid), .sel_id(sel_id),
        .cancel(cancel), .credit(credit), .busy(busy), .product_valid(product_valid),
        .product_id(product_id), .change_valid(change_valid), .change_coin(change_coin),
        .coin_reject(coin_reject), .sel_deny(sel_deny)
    );

    always #5 clk = ~clk;

    // Each entry is what the outputs must show during one busy cycle
    typedef struct {
        bit pv;
        int id;
        bit cv;
        int cc;
        int cr;
    } ent_t;

    ent_t q[$];
    int   mcred = 0;
    bit   erej = 0;
    bit   edeny = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   price[4] = '{20, 35, 50, 65};

    function automatic int coin_value(input int code);
        case (code)
            1: return 5;
            2: return 10;
            3: return 25;
            default: return 0;
        endcase
    endfunction

    task automatic add_change(input int amount);
        int   rem;
        ent_t e;
        rem = amount;
        while (rem > 0) begin
            e.pv = 0; e.id = 0; e.cv = 1; e.cr = rem;
            if (rem >= 25) e.cc = 3;
            else if (rem >= 10) e.cc = 2;
            else e.cc = 1;
            q.push_back(e);
            rem -= coin_value(e.cc);
        end
    endtask

    task automatic model(input int cin, input bit sv, input int sid, input bit cn, input bit r);
        ent_t e;
        if (r) begin
            q.delete();
            mcred = 0; erej = 0; edeny = 0;
        end else if (q.size() > 0) begin
            void'(q.pop_front());
            erej = (cin != 0); edeny = 0;
            if (q.size() == 0) mcred = 0;
        end else begin
            erej = 0; edeny = 0;
            if (cn && mcred > 0) begin
                erej = (cin != 0);
                add_change(mcred);
                mcred = 0;
            end else if (sv && sid < 4 && mcred >= price[sid]) begin
                erej = (cin != 0);
                mcred -= price[sid];
                e.pv = 1; e.id = sid; e.cv = 0; e.cc = 0; e.cr = mcred;
                q.push_back(e);
                add_change(mcred);
                mcred = 0;
            end else begin
                edeny = sv;
                if (cin != 0) begin
                    if (mcred + coin_value(cin) <= 100) mcred += coin_value(cin);
                    else erej = 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit b;
        b = (q.size() > 0);
        chk("credit", int'(credit), b ? q[0].cr : mcred);
        chk("busy", int'(busy), int'(b));
        chk("product_valid", int'(product_valid), b ? int'(q[0].pv) : 0);
        chk("product_id", int'(product_id), b ? q[0].id : 0);
        chk("change_valid", int'(change_valid), b ? int'(q[0].cv) : 0);
        chk("change_coin", int'(change_coin), b ? q[0].cc : 0);
        chk("coin_reject", int'(coin_reject), int'(erej));
        chk("sel_deny", int'(sel_deny), int'(edeny));
    endtask

    task automatic step(input int c, input bit sv, input int sid, input bit cn, input bit r);
        coin = 2'(c); sel_valid = sv; sel_id = 2'(sid); cancel = cn; rst = r;
        @(posedge clk);
        model(c, sv, sid, cn, r);
        #1;
        check_all();
    endtask

    initial begin
        // reset, some traffic, then reset mid-traffic
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(3, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("t1_credit", int'(credit), 0);
        chk("t1_busy", int'(busy), 0);

        // two quarters, buy product 1, change 10 then 5
        step(3, 0, 0, 0, 0);
        step(3, 0, 0, 0, 0);
        chk("t2_credit50", int'(credit), 50);
        step(0, 1, 1, 0, 0);
        chk("t2_pid", int'(product_id), 1);
        step(0, 0, 0, 0, 0);
        chk("t2_chg10", int'(change_coin), 2);
        step(0, 0, 0, 0, 0);
        chk("t2_chg5", int'(change_coin), 1);
        step(0, 0, 0, 0, 0);

        // insufficient credit, then cancel
        step(2, 0, 0, 0, 0);
        step(0, 1, 2, 0, 0);
        chk("t3_deny", int'(sel_deny), 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // fill to ceiling, overflow reject, refund four quarters
        repeat (4) step(3, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("t4_reject", int'(coin_reject), 1);
        chk("t4_credit100", int'(credit), 100);
        step(0, 0, 0, 1, 0);
        repeat (4) step(0, 0, 0, 0, 0);

        // cancel with simultaneous coin; coin during change
        step(2, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0);
        step(3, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // reset in 2nd change cycle
        repeat (3) step(3, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        chk("t6_change_valid", int'(change_valid), 0);
        step(0, 0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            int c, sid;
            bit sv, cn, r;
            c   = ($urandom_range(0, 99) < 45) ? int'($urandom_range(1, 3)) : 0;
            sv  = ($urandom_range(0, 99) < 15);
            sid = int'($urandom_range(0, 3));
            cn  = ($urandom_range(0, 99) < 5);
            r   = ($urandom_range(0, 199) < 1);
            step(c, sv, sid, cn, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
